// File: rtl/bnn_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the binarized MLP.
package bnn_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_OUT_DEF  = 4;
  localparam int BIAS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Accumulator width that holds sum(-N_IN..+N_IN) plus any bias without overflow.
  function automatic int acc_w(input int n_in, input int bias_w);
    int sum_w;
    sum_w = $clog2(n_in + 1) + 1;
    return ((bias_w > sum_w) ? bias_w : sum_w) + 1;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bnn_neuron.sv
// Combinational binarized neuron: XNOR-popcount, bias add, sign activation.
module bnn_neuron
  import bnn_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int ACC_W  = acc_w(N_IN_DEF, BIAS_W_DEF)
) (
  input  logic [N_IN-1:0]   i_x,
  input  logic [N_IN-1:0]   i_w,
  input  logic [BIAS_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_pre,
  output logic              o_act
);

  logic [N_IN-1:0]  w_xnor;
  logic [ACC_W-1:0] w_pop;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_bias_ext;

  assign w_xnor     = ~(i_x ^ i_w);
  assign w_pop      = ACC_W'(popcount(32'(w_xnor)));
  // Map matches to a signed +/-1 sum: 2*pop - N_IN.
  assign w_sum      = (w_pop << 1) - ACC_W'(N_IN);
  assign w_bias_ext = {{(ACC_W - BIAS_W){i_b[BIAS_W-1]}}, i_b};
  assign o_pre      = w_sum + w_bias_ext;
  assign o_act      = ~o_pre[ACC_W-1];

endmodule

// File: rtl/bnn_mlp.sv
// Single-layer binarized MLP, one neuron per clock behind start/busy/done.
// Optional score output enabled by defining BNN_MLP_SCORE_OUT_EN.
module bnn_mlp
  import bnn_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int BIAS_W = BIAS_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_IN-1:0]           in_vec,
  input  logic [N_IN*N_OUT-1:0]     weights,
  input  logic [N_OUT*BIAS_W-1:0]   bias,
  output logic                      busy,
  output logic                      done,
`ifdef BNN_MLP_SCORE_OUT_EN
  output logic [N_OUT*acc_w(N_IN, BIAS_W)-1:0] score,
`endif
  output logic [N_OUT-1:0]          result
);

  localparam int ACC_W = acc_w(N_IN, BIAS_W);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  state_e                    r_state;
  state_e                    w_next_state;
  logic [IDX_W-1:0]          r_idx;
  logic [N_IN-1:0]           r_x;
  logic [N_IN*N_OUT-1:0]     r_w;
  logic [N_OUT*BIAS_W-1:0]   r_b;
  logic [N_OUT-1:0]          r_shadow;
  logic [N_OUT-1:0]          r_result;
  logic                      r_done;
  logic                      r_busy;
  logic [N_IN-1:0]           w_wj;
  logic [BIAS_W-1:0]         w_bj;
  logic [ACC_W-1:0]          w_pre;
  logic                      w_act;

  assign w_wj = r_w[r_idx*N_IN +: N_IN];
  assign w_bj = r_b[r_idx*BIAS_W +: BIAS_W];

  bnn_neuron #(
    .N_IN   (N_IN),
    .BIAS_W (BIAS_W),
    .ACC_W  (ACC_W)
  ) u_neuron (
    .i_x   (r_x),
    .i_w   (w_wj),
    .i_b   (w_bj),
    .o_pre (w_pre),
    .o_act (w_act)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = COMPUTE; else w_next_state = IDLE;
      COMPUTE: if (r_idx == LAST_IDX) w_next_state = DONE; else w_next_state = COMPUTE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand latch, neuron sweep into the shadow, and publication of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_x      <= '0;
      r_w      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      r_busy <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= in_vec;
            r_w   <= weights;
            r_b   <= bias;
            r_idx <= '0;
          end
        end
        COMPUTE: begin
          r_shadow[r_idx] <= w_act;
          r_idx           <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        DONE:    r_result <= r_shadow;
        default: r_idx    <= '0;
      endcase
    end
  end

`ifdef BNN_MLP_SCORE_OUT_EN
  logic [N_OUT*ACC_W-1:0] r_score_sh;
  logic [N_OUT*ACC_W-1:0] r_score;

  // Pre-activation capture follows the same shadow/publish timing as result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score_sh <= '0;
      r_score    <= '0;
    end else if (r_state == COMPUTE) begin
      r_score_sh[r_idx*ACC_W +: ACC_W] <= w_pre;
    end else if (r_state == DONE) begin
      r_score <= r_score_sh;
    end else begin
      r_score <= r_score;
    end
  end

  assign score = r_score;
`else
  logic w_unused_pre;
  assign w_unused_pre = ^w_pre;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_bnn_mlp.sv
// Scoreboard bench for bnn_mlp: directed vectors push expectations, a monitor checks on done.
module tb_bnn_mlp;

  typedef struct {
    logic [3:0]  res;
    logic [19:0] scr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  in_vec;
  logic [15:0] weights;
  logic [15:0] bias;
  logic        busy;
  logic        done;
  logic [3:0]  result;
`ifdef BNN_MLP_SCORE_OUT_EN
  logic [19:0] score;
`endif

  exp_t       q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_done   = 0;
  int         n_pushed = 0;
  logic [3:0] prev_result;

  bnn_mlp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_vec  (in_vec),
    .weights (weights),
    .bias    (bias),
    .busy    (busy),
    .done    (done),
`ifdef BNN_MLP_SCORE_OUT_EN
    .score   (score),
`endif
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
`ifdef BNN_MLP_SCORE_OUT_EN
        check("score", 32'(score), 32'(e.scr));
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] x, input logic [15:0] w, input logic [15:0] b,
                       input logic [3:0] res, input logic [19:0] scr, input bit interfere);
    exp_t e;
    @(negedge clk);
    in_vec = x; weights = w; bias = b; start = 1'b1;
    e.res = res; e.scr = scr;
    q.push_back(e);
    n_pushed++;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (interfere) begin
        start = (k == 1 || k == 3);
        in_vec = ~x; weights = ~w; bias = ~b;
      end
      @(posedge clk); #1;
      check("busy_compute", 32'(busy), 32'd1);
      check("no_early_done", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(prev_result));
    end
    @(negedge clk);
    if (interfere) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_vec = x; weights = w; bias = b;
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_stays_low", 32'(busy), 32'd0);
    prev_result = res;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_vec = 4'd0; weights = 16'd0; bias = 16'd0;
    prev_result = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b1111, 16'hFFFF, 16'h0000, 4'b1111, {5'd4, 5'd4, 5'd4, 5'd4}, 1'b0);

    // Abort mid-COMPUTE: outputs clear immediately and no done follows.
    @(negedge clk);
    in_vec = 4'b0000; weights = 16'hFFFF; bias = 16'h7777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
`ifdef BNN_MLP_SCORE_OUT_EN
    check("abort_score", 32'(score), 32'd0);
`endif
    prev_result = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    issue(4'b0000, 16'hFFFF, 16'h0000, 4'b0000, {5'h1C, 5'h1C, 5'h1C, 5'h1C}, 1'b0);
    issue(4'b0011, 16'hFFFF, 16'h0F00, 4'b1011, {5'd0, 5'h1F, 5'd0, 5'd0}, 1'b0);
    issue(4'b0000, 16'hFFFF, 16'h7777, 4'b1111, {5'd3, 5'd3, 5'd3, 5'd3}, 1'b0);
    issue(4'b1111, 16'hFFFF, 16'h8888, 4'b0000, {5'h1C, 5'h1C, 5'h1C, 5'h1C}, 1'b0);
    issue(4'b1010, 16'h05AF, 16'h1F2E, 4'b1010, {5'd1, 5'h1B, 5'd6, 5'h1E}, 1'b0);
    issue(4'b1111, 16'hFFFF, 16'h0000, 4'b1111, {5'd4, 5'd4, 5'd4, 5'd4}, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    check("done_count", 32'(n_done), 32'(n_pushed));
    check("queue_empty", 32'(q.size()), 32'd0);
    check("final_result_held", 32'(result), 32'(prev_result));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
